// File: rtl/hex_trace_display_pkg.sv
// rtl/hex_trace_display_pkg.sv - shared segment patterns, FSM encoding and history depth
package hex_trace_display_pkg;

  localparam int HIST_DEPTH = 8;

  // Active-low segments, bit 6 = a .. bit 0 = g
  localparam logic [6:0] SEG_0    = 7'b0000001;
  localparam logic [6:0] SEG_1    = 7'b1001111;
  localparam logic [6:0] SEG_2    = 7'b0010010;
  localparam logic [6:0] SEG_3    = 7'b0000110;
  localparam logic [6:0] SEG_4    = 7'b1001100;
  localparam logic [6:0] SEG_5    = 7'b0100100;
  localparam logic [6:0] SEG_6    = 7'b0100000;
  localparam logic [6:0] SEG_7    = 7'b0001111;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0001100;
  localparam logic [6:0] SEG_A    = 7'b0001000;
  localparam logic [6:0] SEG_B    = 7'b1100000;
  localparam logic [6:0] SEG_C    = 7'b0110001;
  localparam logic [6:0] SEG_D    = 7'b1000010;
  localparam logic [6:0] SEG_E    = 7'b0110000;
  localparam logic [6:0] SEG_F    = 7'b0111000;
  localparam logic [6:0] SEG_VOID = 7'b1111111;

  typedef enum logic {
    ST_LIVE = 1'b0,
    ST_HOLD = 1'b1
  } trace_state_t;

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    case (d)
      4'h0: hex_seg = SEG_0;
      4'h1: hex_seg = SEG_1;
      4'h2: hex_seg = SEG_2;
      4'h3: hex_seg = SEG_3;
      4'h4: hex_seg = SEG_4;
      4'h5: hex_seg = SEG_5;
      4'h6: hex_seg = SEG_6;
      4'h7: hex_seg = SEG_7;
      4'h8: hex_seg = SEG_8;
      4'h9: hex_seg = SEG_9;
      4'hA: hex_seg = SEG_A;
      4'hB: hex_seg = SEG_B;
      4'hC: hex_seg = SEG_C;
      4'hD: hex_seg = SEG_D;
      4'hE: hex_seg = SEG_E;
      default: hex_seg = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/hex_trace_display_btn_debounce.sv
// rtl/hex_trace_display_btn_debounce.sv - button synchronizer, debounce counter and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_n;
  logic          sync2_n;
  logic          level_n;
  logic          armed;
  logic [CW-1:0] cnt;

  // Synchronizer resets to "pressed" so a button held through reset never arms
  // until it has been seen released.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_n <= 1'b0;
      sync2_n <= 1'b0;
      level_n <= 1'b1;
      armed   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync1_n <= btn_n;
      sync2_n <= sync1_n;
      press   <= 1'b0;
      if (level_n && sync2_n) armed <= 1'b1;
      if (sync2_n == level_n) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        level_n <= sync2_n;
        press   <= armed & ~sync2_n;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_trace_display.sv
// rtl/hex_trace_display.sv - 8-deep pc/wd trace buffer shown on six seven-segment digits
module hex_trace_display
  import hex_trace_display_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_step,
  input  logic [31:0] pc_val,
  input  logic [31:0] wd_val,
  input  logic        btn_hold_n,
  input  logic        btn_prev_n,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic        hold_led,
  output logic [3:0]  hist_count,
  output logic [2:0]  view_offset
);

  localparam logic [3:0] HIST_FULL = 4'(HIST_DEPTH);

  trace_state_t state, state_n;
  logic [2:0]   wr_ptr, ptr_n, view_n, idx_n;
  logic [3:0]   count_n;
  logic         wr_en, hold_press, prev_press;
  logic [23:0]  hist_mem [HIST_DEPTH];
  logic [23:0]  entry_n;

  wire unused_ok = &{1'b0, pc_val[31:8], wd_val[31:16]};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold (
    .clock(clock), .reset(reset), .btn_n(btn_hold_n), .press(hold_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .clock(clock), .reset(reset), .btn_n(btn_prev_n), .press(prev_press)
  );

  always_comb begin
    state_n = state;
    ptr_n   = wr_ptr;
    count_n = hist_count;
    view_n  = view_offset;
    wr_en   = 1'b0;
    case (state)
      ST_LIVE: begin
        if (cpu_step) begin
          wr_en = 1'b1;
          ptr_n = wr_ptr + 3'd1;
          if (hist_count != HIST_FULL) count_n = hist_count + 4'd1;
        end
        if (hold_press) begin
          state_n = ST_HOLD;
          view_n  = '0;
        end
      end
      ST_HOLD: begin
        // A hold press wins over a coincident prev press.
        if (hold_press) begin
          state_n = ST_LIVE;
          view_n  = '0;
        end else if (prev_press) begin
          if (hist_count <= 4'd1 || {1'b0, view_offset} == hist_count - 4'd1) view_n = '0;
          else view_n = view_offset + 3'd1;
        end
      end
    endcase
  end

  // A fresh write is always the newest entry, so it bypasses the buffer read.
  assign idx_n   = ptr_n - 3'd1 - view_n;
  assign entry_n = wr_en ? {pc_val[7:0], wd_val[15:0]} : hist_mem[idx_n];

  always_ff @(posedge clock) begin
    if (wr_en) hist_mem[wr_ptr] <= {pc_val[7:0], wd_val[15:0]};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= ST_LIVE;
      wr_ptr      <= '0;
      hist_count  <= '0;
      view_offset <= '0;
      hold_led    <= 1'b0;
      hex5        <= SEG_VOID;
      hex4        <= SEG_VOID;
      hex3        <= SEG_VOID;
      hex2        <= SEG_VOID;
      hex1        <= SEG_VOID;
      hex0        <= SEG_VOID;
    end else begin
      state       <= state_n;
      wr_ptr      <= ptr_n;
      hist_count  <= count_n;
      view_offset <= view_n;
      hold_led    <= (state_n == ST_HOLD);
      if (count_n == 4'd0) begin
        hex5 <= SEG_VOID;
        hex4 <= SEG_VOID;
        hex3 <= SEG_VOID;
        hex2 <= SEG_VOID;
        hex1 <= SEG_VOID;
        hex0 <= SEG_VOID;
      end else begin
        hex5 <= hex_seg(entry_n[23:20]);
        hex4 <= hex_seg(entry_n[19:16]);
        hex3 <= hex_seg(entry_n[15:12]);
        hex2 <= hex_seg(entry_n[11:8]);
        hex1 <= hex_seg(entry_n[7:4]);
        hex0 <= hex_seg(entry_n[3:0]);
      end
    end
  end

endmodule

// File: tb/tb_hex_trace_display.sv
// tb/tb_hex_trace_display.sv - directed self-checking bench for hex_trace_display
module tb_hex_trace_display;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_step = 1'b0;
  logic [31:0] pc_val = '0;
  logic [31:0] wd_val = '0;
  logic        btn_hold_n = 1'b1;
  logic        btn_prev_n = 1'b1;
  logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
  logic        hold_led;
  logic [3:0]  hist_count;
  logic [2:0]  view_offset;

  int total = 0;
  int bad = 0;

  localparam logic [41:0] BLANK = {6{7'b1111111}};

  hex_trace_display #(.DEBOUNCE_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .cpu_step(cpu_step), .pc_val(pc_val), .wd_val(wd_val),
    .btn_hold_n(btn_hold_n), .btn_prev_n(btn_prev_n),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .hold_led(hold_led), .hist_count(hist_count), .view_offset(view_offset)
  );

  always #5 clock = ~clock;

  wire [41:0] hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;  4'h9: return 7'b0001100;
      4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;  default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [41:0] disp(input logic [7:0] pc, input logic [15:0] wd);
    return {seg(pc[7:4]), seg(pc[3:0]), seg(wd[15:12]), seg(wd[11:8]), seg(wd[7:4]), seg(wd[3:0])};
  endfunction

  // Fill pattern: wd tracks pc so every digit is predictable.
  function automatic logic [41:0] fdisp(input logic [7:0] pc);
    return disp(pc, 16'h1000 + {8'h00, pc});
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic step(input logic [31:0] pc, input logic [31:0] wd);
    cpu_step = 1'b1;
    pc_val = pc;
    wd_val = wd;
    tick();
    cpu_step = 1'b0;
  endtask

  task automatic press_hold();
    btn_hold_n = 1'b0; tick(8); btn_hold_n = 1'b1; tick(8);
  endtask

  task automatic press_prev();
    btn_prev_n = 1'b0; tick(8); btn_prev_n = 1'b1; tick(8);
  endtask

  task automatic press_both();
    btn_hold_n = 1'b0; btn_prev_n = 1'b0; tick(8);
    btn_hold_n = 1'b1; btn_prev_n = 1'b1; tick(8);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(3);
    total++; if (hex_all !== BLANK) begin bad++; $display("FAIL reset_hex: got %h want %h", hex_all, BLANK); end
    total++; if (hold_led !== 1'b0) begin bad++; $display("FAIL reset_led: got %b want 0", hold_led); end
    reset = 1'b1;
    tick(5);
    total++; if (hist_count !== 4'd0) begin bad++; $display("FAIL idle_count: got %0d want 0", hist_count); end
    total++; if (hex_all !== BLANK) begin bad++; $display("FAIL idle_hex: got %h want %h", hex_all, BLANK); end
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL idle_view: got %0d want 0", view_offset); end
  endtask

  task automatic test_single_step();
    logic [41:0] exp;
    exp = {7'b1001111, 7'b1001100, 7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010};
    step(32'h0000_0014, 32'h0000_ABCD);
    total++; if (hex_all !== exp) begin bad++; $display("FAIL single_hex: got %h want %h", hex_all, exp); end
    total++; if (hist_count !== 4'd1) begin bad++; $display("FAIL single_count: got %0d want 1", hist_count); end
  endtask

  task automatic test_fill();
    reset = 1'b0; tick(); reset = 1'b1; tick(4);
    for (int i = 0; i < 10; i++) begin
      step(32'(i * 4), 32'(16'h1000 + i * 4));
      total++;
      if (hist_count !== ((i + 1 > 8) ? 4'd8 : 4'(i + 1))) begin
        bad++; $display("FAIL fill_count_%0d: got %0d want %0d", i, hist_count, (i + 1 > 8) ? 8 : i + 1);
      end
    end
    total++; if (dut.wr_ptr !== 3'd2) begin bad++; $display("FAIL fill_ptr: got %0d want 2", dut.wr_ptr); end
    total++; if (hex_all !== fdisp(8'h24)) begin bad++; $display("FAIL fill_hex: got %h want %h", hex_all, fdisp(8'h24)); end
  endtask

  task automatic test_hold_prev();
    press_hold();
    total++; if (hold_led !== 1'b1) begin bad++; $display("FAIL hold_led: got %b want 1", hold_led); end
    total++; if (hex_all !== fdisp(8'h24)) begin bad++; $display("FAIL hold_hex: got %h want %h", hex_all, fdisp(8'h24)); end
    for (int k = 1; k <= 3; k++) begin
      press_prev();
      total++; if (view_offset !== 3'(k)) begin bad++; $display("FAIL prev_view_%0d: got %0d want %0d", k, view_offset, k); end
      total++;
      if (hex_all !== fdisp(8'(8'h24 - 4 * k))) begin
        bad++; $display("FAIL prev_hex_%0d: got %h want %h", k, hex_all, fdisp(8'(8'h24 - 4 * k)));
      end
    end
    step(32'h99, 32'h5555);
    step(32'h98, 32'h6666);
    total++; if (hist_count !== 4'd8) begin bad++; $display("FAIL hold_step_count: got %0d want 8", hist_count); end
    total++; if (dut.wr_ptr !== 3'd2) begin bad++; $display("FAIL hold_step_ptr: got %0d want 2", dut.wr_ptr); end
    total++; if (hex_all !== fdisp(8'h18)) begin bad++; $display("FAIL hold_step_hex: got %h want %h", hex_all, fdisp(8'h18)); end
  endtask

  task automatic test_glitch_and_wrap();
    btn_prev_n = 1'b0; tick(2); btn_prev_n = 1'b1; tick(10);
    total++; if (view_offset !== 3'd3) begin bad++; $display("FAIL glitch_view: got %0d want 3", view_offset); end
    btn_prev_n = 1'b0; tick(6); btn_prev_n = 1'b1; tick(10);
    total++; if (view_offset !== 3'd4) begin bad++; $display("FAIL press6_view: got %0d want 4", view_offset); end
    total++; if (hex_all !== fdisp(8'h14)) begin bad++; $display("FAIL press6_hex: got %h want %h", hex_all, fdisp(8'h14)); end
    press_prev(); press_prev(); press_prev();
    total++; if (view_offset !== 3'd7) begin bad++; $display("FAIL oldest_view: got %0d want 7", view_offset); end
    total++; if (hex_all !== fdisp(8'h08)) begin bad++; $display("FAIL oldest_hex: got %h want %h", hex_all, fdisp(8'h08)); end
    press_prev();
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL wrap_view: got %0d want 0", view_offset); end
    total++; if (hex_all !== fdisp(8'h24)) begin bad++; $display("FAIL wrap_hex: got %h want %h", hex_all, fdisp(8'h24)); end
  endtask

  task automatic test_coincident_buttons();
    press_prev();
    press_both();
    total++; if (hold_led !== 1'b0) begin bad++; $display("FAIL both_to_live_led: got %b want 0", hold_led); end
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL both_to_live_view: got %0d want 0", view_offset); end
    press_prev();
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL live_prev_view: got %0d want 0", view_offset); end
    press_both();
    total++; if (hold_led !== 1'b1) begin bad++; $display("FAIL both_to_hold_led: got %b want 1", hold_led); end
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL both_to_hold_view: got %0d want 0", view_offset); end
    press_hold();
  endtask

  task automatic test_step_with_hold();
    // Press pulse reaches the FSM on the 7th edge after the raw button falls.
    btn_hold_n = 1'b0;
    tick(6);
    step(32'h28, 32'h1028);
    total++; if (hold_led !== 1'b1) begin bad++; $display("FAIL step_hold_led: got %b want 1", hold_led); end
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL step_hold_view: got %0d want 0", view_offset); end
    total++; if (hex_all !== fdisp(8'h28)) begin bad++; $display("FAIL step_hold_hex: got %h want %h", hex_all, fdisp(8'h28)); end
    total++; if (dut.wr_ptr !== 3'd3) begin bad++; $display("FAIL step_hold_ptr: got %0d want 3", dut.wr_ptr); end
    btn_hold_n = 1'b1;
    tick(8);
  endtask

  task automatic test_reset_in_hold();
    press_prev(); press_prev(); press_prev();
    total++; if (view_offset !== 3'd3) begin bad++; $display("FAIL pre_reset_view: got %0d want 3", view_offset); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (hold_led !== 1'b0) begin bad++; $display("FAIL async_led: got %b want 0", hold_led); end
    total++; if (hist_count !== 4'd0) begin bad++; $display("FAIL async_count: got %0d want 0", hist_count); end
    total++; if (view_offset !== 3'd0) begin bad++; $display("FAIL async_view: got %0d want 0", view_offset); end
    total++; if (hex_all !== BLANK) begin bad++; $display("FAIL async_hex: got %h want %h", hex_all, BLANK); end
    btn_hold_n = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(12);
    total++; if (hold_led !== 1'b0) begin bad++; $display("FAIL held_through_reset: got %b want 0", hold_led); end
    btn_hold_n = 1'b1;
    tick(8);
    press_hold();
    total++; if (hold_led !== 1'b1) begin bad++; $display("FAIL repress_led: got %b want 1", hold_led); end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_fill();
    test_hold_prev();
    test_glitch_and_wrap();
    test_coincident_buttons();
    test_step_with_hold();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_trace_display.md
HEX_TRACE_DISPLAY -- requirements
Module: hex_trace_display

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 250000: consecutive stable cycles needed before a debounced button level changes.
REQ-002 clock  input  1  system clock, shared with the mips core.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_step  input  1  one-cycle pulse when the core commits an instruction; pc_val/wd_val valid in that cycle.
REQ-005 pc_val  input  32  core program counter (PC_val).
REQ-006 wd_val  input  32  core register write-data (WD_val).
REQ-007 btn_hold_n  input  1  raw, asynchronous, active-low hold/run toggle button.
REQ-008 btn_prev_n  input  1  raw, asynchronous, active-low "show older entry" button.
REQ-009 hex5, hex4  output  7 each  active-low segments for pc[7:4] and pc[3:0].
REQ-010 hex3..hex0  output  7 each  active-low segments for wd[15:12], wd[11:8], wd[7:4] and wd[3:0].
REQ-011 hold_led  output  1  high while in HOLD.
REQ-012 hist_count  output  4  number of valid history entries, 0..8.
REQ-013 view_offset  output  3  age of the displayed entry (0 = newest).

Function
REQ-014 The block SHALL keep an 8-entry ring buffer of 24-bit entries {pc_val[7:0], wd_val[15:0]}, with a 3-bit write pointer and a hist_count that saturates at 8.
REQ-015 The FSM SHALL have two states: LIVE and HOLD.
REQ-016 In LIVE, each cpu_step SHALL write an entry at the write pointer, advance the pointer (7 wraps to 0), and increment hist_count up to 8; when full, the oldest entry is overwritten.
REQ-017 In HOLD, cpu_step SHALL be ignored: no write, and neither the pointer nor hist_count changes.
REQ-018 A debounced press of btn_hold_n SHALL toggle LIVE/HOLD; every transition SHALL clear view_offset to 0.
REQ-019 A debounced press of btn_prev_n in HOLD SHALL increment view_offset, wrapping to 0 after hist_count-1; with hist_count of 0 or 1, view_offset SHALL stay 0.
REQ-020 btn_prev_n presses in LIVE SHALL be ignored.
REQ-021 The displayed entry SHALL be at index (write pointer - 1 - view_offset) mod 8.
REQ-022 The hex outputs SHALL be registered and reflect a write or offset change exactly one cycle later.
REQ-023 When hist_count is 0, all six hex outputs SHALL be 7'b111_1111 (blank).
REQ-024 If cpu_step and a hold press occur in the same LIVE cycle, the entry SHALL be written first, then HOLD entered showing that entry.
REQ-025 If hold and prev presses coincide, the hold press SHALL take effect and the prev press SHALL be discarded.
REQ-026 Debounce: each raw button SHALL pass through a 2-flop synchronizer.
REQ-027 The debounced level SHALL change only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-028 A press event SHALL be a single-cycle pulse on the debounced transition to the pressed (low) level.

Reset
REQ-029 While reset is low, the block SHALL asynchronously set: state LIVE, pointer 0, hist_count 0, view_offset 0, hold_led 0, all hex outputs 7'b111_1111, debounced levels released.
REQ-030 Buffer contents need not be cleared; hist_count=0 masks them.
REQ-031 A reset asserted mid-press SHALL require the button to be released and re-pressed before a new press event is produced.

Structure
REQ-032 A shared package SHALL hold the active-low segment constants SEG_0..SEG_F and SEG_VOID (bit 6 = a .. bit 0 = g, 0 = lit):
  0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111,
  8=0000000, 9=0001100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000, void=1111111.
REQ-033 The package SHALL also hold the FSM state encoding and HIST_DEPTH=8.
REQ-034 One sub-module, btn_debounce (synchronizer, counter, press pulse), SHALL be instantiated twice.

Verification (DEBOUNCE_CYCLES=4)
REQ-035 Release reset, no steps -> hist_count=0 and all hex = 1111111.
REQ-036 One step with pc=0x0000_0014, wd=0x0000_ABCD -> next cycle hex5..hex0 = 1,4,A,b,C,d patterns; hist_count=1.
REQ-037 Ten steps with pc=0x00..0x24 (step 4) -> hist_count=8, pointer=2, display shows pc 0x24.
REQ-038 Hold press, then three prev presses -> hold_led=1 and displayed pc = 0x20, 0x1C, 0x18; steps issued while in HOLD leave hist_count and the display unchanged.
REQ-039 prev glitch of 2 cycles -> no event; press held 6 cycles -> exactly one event; simultaneous step and hold press -> new entry shown in HOLD with view_offset 0.
REQ-040 Reset pulsed while in HOLD with view_offset=3 -> LIVE, blank display, hist_count=0, immediately.
